// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - handshake and strobe bundle between the sequencer and the datapath/memories
interface multicycle_ctrl_if #(
   parameter int CNT_W = 32
);
   logic             start_i;
   logic [5:0]       op_i;
   logic             zero_i;
   logic             imem_req_o;
   logic             imem_ack_i;
   logic             dmem_req_o;
   logic             dmem_we_o;
   logic             dmem_ack_i;
   logic             ir_write_o;
   logic             pc_write_o;
   logic             pc_src_o;
   logic             reg_dst_o;
   logic             alu_src_o;
   logic [1:0]       alu_op_o;
   logic             mem_to_reg_o;
   logic             reg_write_o;
   logic             busy_o;
   logic             err_o;
   logic [CNT_W-1:0] retired_o;

   modport master (
      input  start_i, op_i, zero_i, imem_ack_i, dmem_ack_i,
      output imem_req_o, dmem_req_o, dmem_we_o, ir_write_o, pc_write_o, pc_src_o,
             reg_dst_o, alu_src_o, alu_op_o, mem_to_reg_o, reg_write_o, busy_o,
             err_o, retired_o
   );

   modport slave (
      output start_i, op_i, zero_i, imem_ack_i, dmem_ack_i,
      input  imem_req_o, dmem_req_o, dmem_we_o, ir_write_o, pc_write_o, pc_src_o,
             reg_dst_o, alu_src_o, alu_op_o, mem_to_reg_o, reg_write_o, busy_o,
             err_o, retired_o
   );
endinterface

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the MIPS-subset datapath
// State-decoded strobes are registered from the next state; only ack/zero-qualified strobes are combinational.
module multicycle_ctrl #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   multicycle_ctrl_if.master bus
);
   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;

   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [TW-1:0] TMO_LIM = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_ERROR
   } state_t;

   state_t           state_q, state_d;
   logic [5:0]       op_q, op_d;
   logic [TW-1:0]    tmo_q, tmo_d;
   logic [CNT_W-1:0] retired_q, retired_d;
   logic             imem_req_q, imem_req_d;
   logic             dmem_req_q, dmem_req_d;
   logic             dmem_we_q, dmem_we_d;
   logic             pc_src_q, pc_src_d;
   logic             reg_dst_q, reg_dst_d;
   logic             alu_src_q, alu_src_d;
   logic [1:0]       alu_op_q, alu_op_d;
   logic             mem_to_reg_q, mem_to_reg_d;
   logic             reg_write_q, reg_write_d;
   logic             busy_q, busy_d;
   logic             err_q, err_d;
   logic             fetch_ack, mem_ack, tmo_hit, retire, op_legal;

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      retired_d = retired_q;
      retire    = 1'b0;
      fetch_ack = (state_q == S_FETCH) && bus.imem_ack_i;
      mem_ack   = (state_q == S_MEM) && bus.dmem_ack_i;
      tmo_hit   = (TIMEOUT != 0) && (tmo_q == TMO_LIM);
      op_legal  = bus.op_i inside {OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ};

      case (state_q)
         S_IDLE:   if (bus.start_i) state_d = S_FETCH;
         S_FETCH: begin
            // an ack on the limit cycle takes priority over the timeout
            if (fetch_ack)    state_d = S_DECODE;
            else if (tmo_hit) state_d = S_ERROR;
         end
         S_DECODE: begin
            op_d    = bus.op_i;
            state_d = op_legal ? S_EXEC : S_ERROR;
         end
         S_EXEC: begin
            if (op_q == OP_BEQ)                         retire  = 1'b1;
            else if (op_q == OP_LW || op_q == OP_SW)    state_d = S_MEM;
            else                                        state_d = S_WB;
         end
         S_MEM: begin
            if (mem_ack) begin
               if (op_q == OP_SW) retire  = 1'b1;
               else               state_d = S_WB;
            end else if (tmo_hit) begin
               state_d = S_ERROR;
            end
         end
         S_WB:     retire = 1'b1;
         S_ERROR:  state_d = S_ERROR;
         default:  state_d = S_IDLE;
      endcase

      if (retire) begin
         retired_d = retired_q + 1'b1;
         state_d   = bus.start_i ? S_FETCH : S_IDLE;
      end

      tmo_d = '0;
      if ((TIMEOUT != 0) && (state_d == state_q) && (state_q == S_FETCH || state_q == S_MEM))
         tmo_d = tmo_q + 1'b1;

      imem_req_d   = (state_d == S_FETCH);
      dmem_req_d   = (state_d == S_MEM);
      dmem_we_d    = (state_d == S_MEM) && (op_d == OP_SW);
      pc_src_d     = (state_d == S_EXEC) && (op_d == OP_BEQ);
      reg_write_d  = (state_d == S_WB);
      reg_dst_d    = (state_d == S_WB) && (op_d == OP_R);
      mem_to_reg_d = (state_d == S_WB) && (op_d == OP_LW);
      busy_d       = !(state_d inside {S_IDLE, S_ERROR});
      err_d        = (state_d == S_ERROR);
      alu_src_d    = 1'b0;
      alu_op_d     = 2'b00;
      if (state_d inside {S_EXEC, S_MEM, S_WB}) begin
         alu_src_d = op_d inside {OP_ADDI, OP_LW, OP_SW};
         alu_op_d  = (op_d == OP_R) ? 2'b10 : ((op_d == OP_BEQ) ? 2'b01 : 2'b00);
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q      <= S_IDLE;
         op_q         <= '0;
         tmo_q        <= '0;
         retired_q    <= '0;
         imem_req_q   <= 1'b0;
         dmem_req_q   <= 1'b0;
         dmem_we_q    <= 1'b0;
         pc_src_q     <= 1'b0;
         reg_dst_q    <= 1'b0;
         alu_src_q    <= 1'b0;
         alu_op_q     <= 2'b00;
         mem_to_reg_q <= 1'b0;
         reg_write_q  <= 1'b0;
         busy_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         tmo_q        <= tmo_d;
         retired_q    <= retired_d;
         imem_req_q   <= imem_req_d;
         dmem_req_q   <= dmem_req_d;
         dmem_we_q    <= dmem_we_d;
         pc_src_q     <= pc_src_d;
         reg_dst_q    <= reg_dst_d;
         alu_src_q    <= alu_src_d;
         alu_op_q     <= alu_op_d;
         mem_to_reg_q <= mem_to_reg_d;
         reg_write_q  <= reg_write_d;
         busy_q       <= busy_d;
         err_q        <= err_d;
      end
   end

   // IR/PC loads must land on the ack cycle itself, and the branch PC load follows the live zero flag
   assign bus.ir_write_o   = imem_req_q & bus.imem_ack_i;
   assign bus.pc_write_o   = (imem_req_q & bus.imem_ack_i) | (pc_src_q & bus.zero_i);
   assign bus.imem_req_o   = imem_req_q;
   assign bus.dmem_req_o   = dmem_req_q;
   assign bus.dmem_we_o    = dmem_we_q;
   assign bus.pc_src_o     = pc_src_q;
   assign bus.reg_dst_o    = reg_dst_q;
   assign bus.alu_src_o    = alu_src_q;
   assign bus.alu_op_o     = alu_op_q;
   assign bus.mem_to_reg_o = mem_to_reg_q;
   assign bus.reg_write_o  = reg_write_q;
   assign bus.busy_o       = busy_q;
   assign bus.err_o        = err_q;
   assign bus.retired_o    = retired_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - scoreboard bench for multicycle_ctrl
module tb_multicycle_ctrl;
   localparam int CNT_W = 3;
   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;

   // {ir_write, pc_write, pc_src, reg_write, reg_dst, mem_to_reg, alu_src, alu_op, dmem_req, dmem_we, err, busy}
   localparam logic [12:0] V_FETCH   = 13'b1_1_0_0_0_0_0_00_0_0_0_1;
   localparam logic [12:0] V_WB_R    = 13'b0_0_0_1_1_0_0_10_0_0_0_1;
   localparam logic [12:0] V_WB_ADDI = 13'b0_0_0_1_0_0_1_00_0_0_0_1;
   localparam logic [12:0] V_WB_LW   = 13'b0_0_0_1_0_1_1_00_0_0_0_1;
   localparam logic [12:0] V_MEM_LW  = 13'b0_0_0_0_0_0_1_00_1_0_0_1;
   localparam logic [12:0] V_MEM_SW  = 13'b0_0_0_0_0_0_1_00_1_1_0_1;
   localparam logic [12:0] V_BEQ_T   = 13'b0_1_1_0_0_0_0_01_0_0_0_1;
   localparam logic [12:0] V_BEQ_N   = 13'b0_0_1_0_0_0_0_01_0_0_0_1;
   localparam logic [12:0] V_ERR     = 13'b0_0_0_0_0_0_0_00_0_0_1_0;

   typedef struct {
      int         cyc;
      logic [12:0] v;
   } ev_t;

   logic             clk;
   logic             rst_n;
   logic             stray;
   int               cyc = 0;
   int               t0 = 0;
   int               n_chk = 0;
   int               n_err = 0;
   int               imem_wait = 0;
   int               dmem_wait = 0;
   int               ireq_cnt = 0;
   int               dreq_cnt = 0;
   int               base;
   logic [CNT_W-1:0] exp_ret;
   ev_t              sb[$];
   logic [12:0]      snap;
   logic [13:0]      outs;

   multicycle_ctrl_if #(.CNT_W(CNT_W)) bus ();

   multicycle_ctrl #(.TIMEOUT(16), .CNT_W(CNT_W)) dut (
      .clk_i (clk),
      .rst_i (rst_n),
      .bus   (bus)
   );

   assign snap = {bus.ir_write_o, bus.pc_write_o, bus.pc_src_o, bus.reg_write_o, bus.reg_dst_o,
                  bus.mem_to_reg_o, bus.alu_src_o, bus.alu_op_o, bus.dmem_req_o, bus.dmem_we_o,
                  bus.err_o, bus.busy_o};
   assign outs = {bus.imem_req_o, snap};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
      end
   endtask

   // memory responder: acks after a programmed number of wait cycles; optional acks while idle
   initial begin
      int icnt, dcnt;
      icnt = 0;
      dcnt = 0;
      bus.imem_ack_i = 1'b0;
      bus.dmem_ack_i = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         if (!rst_n) begin
            icnt = 0;
            dcnt = 0;
            bus.imem_ack_i = 1'b0;
            bus.dmem_ack_i = 1'b0;
         end else begin
            if (bus.imem_req_o) begin
               bus.imem_ack_i = (icnt == imem_wait);
               icnt = (icnt == imem_wait) ? 0 : icnt + 1;
            end else begin
               bus.imem_ack_i = stray;
               icnt = 0;
            end
            if (bus.dmem_req_o) begin
               bus.dmem_ack_i = (dcnt == dmem_wait);
               dcnt = (dcnt == dmem_wait) ? 0 : dcnt + 1;
            end else begin
               bus.dmem_ack_i = stray;
               dcnt = 0;
            end
         end
      end
   end

   // monitor: every strobe event, memory completion or error entry is matched against the scoreboard
   initial begin
      logic err_prev;
      ev_t  e;
      err_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            err_prev = 1'b0;
         end else begin
            if (bus.imem_req_o) ireq_cnt++;
            if (bus.dmem_req_o) dreq_cnt++;
            if (bus.ir_write_o || bus.pc_write_o || bus.pc_src_o || bus.reg_write_o ||
                (bus.dmem_req_o && bus.dmem_ack_i) || (bus.err_o && !err_prev)) begin
               if (sb.size() == 0) begin
                  n_chk++;
                  n_err++;
                  $display("FAIL unexpected_event: got vec %b at cycle %0d expected no event", snap, cyc);
               end else begin
                  e = sb.pop_front();
                  chk("event_cycle", cyc, e.cyc);
                  chk("event_vec", 32'(snap), 32'(e.v));
               end
            end
            err_prev = bus.err_o;
         end
      end
   end

   task automatic at(input int rel);
      while (cyc < t0 + rel) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic go(input logic [5:0] op);
      bus.op_i    = op;
      bus.start_i = 1'b1;
      t0          = cyc;
   endtask

   task automatic expect_ev(input int rel, input logic [12:0] v);
      ev_t e;
      e.cyc = t0 + rel;
      e.v   = v;
      sb.push_back(e);
   endtask

   task automatic done(input string nm);
      chk({nm, "_pending"}, 32'(sb.size()), 32'd0);
      chk({nm, "_retired"}, 32'(bus.retired_o), 32'(exp_ret));
   endtask

   task automatic do_reset(input string nm);
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk({nm, "_outs"}, 32'(outs), 32'd0);
      chk({nm, "_retired"}, 32'(bus.retired_o), 32'd0);
      rst_n       = 1'b1;
      bus.start_i = 1'b0;
      stray       = 1'b0;
      imem_wait   = 0;
      dmem_wait   = 0;
      exp_ret     = '0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n       = 1'b0;
      stray       = 1'b0;
      bus.start_i = 1'b0;
      bus.op_i    = 6'd0;
      bus.zero_i  = 1'b0;
      exp_ret     = '0;
      do_reset("reset");

      go(OP_R);
      expect_ev(1, V_FETCH);
      expect_ev(4, V_WB_R);
      at(1); bus.start_i = 1'b0;
      at(6); exp_ret++; done("r_type");

      dmem_wait = 3;
      base = dreq_cnt;
      go(OP_LW);
      expect_ev(1, V_FETCH);
      expect_ev(7, V_MEM_LW);
      expect_ev(8, V_WB_LW);
      at(1); bus.start_i = 1'b0;
      at(10);
      chk("lw_dmem_req_cycles", dreq_cnt - base, 4);
      dmem_wait = 0;
      exp_ret++; done("lw_wait");

      bus.zero_i = 1'b1;
      go(OP_BEQ);
      expect_ev(1, V_FETCH);
      expect_ev(3, V_BEQ_T);
      expect_ev(4, V_FETCH);
      expect_ev(6, V_BEQ_N);
      at(4); bus.zero_i = 1'b0; bus.start_i = 1'b0;
      at(8); exp_ret += 2; done("beq_pair");

      stray = 1'b1;
      go(OP_ADDI);
      expect_ev(1, V_FETCH);
      expect_ev(4, V_WB_ADDI);
      at(1); bus.start_i = 1'b0;
      at(7); stray = 1'b0;
      exp_ret++; done("addi_stray_ack");

      go(OP_SW);
      expect_ev(1, V_FETCH);
      expect_ev(4, V_MEM_SW);
      at(3); bus.start_i = 1'b0;
      at(6);
      chk("sw_stop_busy", 32'(bus.busy_o), 32'd0);
      exp_ret++; done("sw_start_drop");

      go(OP_BEQ);
      for (int k = 0; k < 4; k++) begin
         expect_ev(1 + 3 * k, V_FETCH);
         expect_ev(3 + 3 * k, V_BEQ_N);
      end
      at(10); bus.start_i = 1'b0;
      at(14); exp_ret += 4; done("retire_wrap");

      go(6'b111111);
      expect_ev(1, V_FETCH);
      expect_ev(3, V_ERR);
      at(1); bus.start_i = 1'b0;
      at(5);
      for (int i = 0; i < 6; i++) begin
         bus.start_i = i[0];
         @(posedge clk);
         #1;
      end
      bus.start_i = 1'b0;
      chk("illegal_outs", 32'(outs), 32'(14'b00_0000_0000_0010));
      done("illegal");
      do_reset("illegal_reset");

      imem_wait = 1000;
      base = ireq_cnt;
      go(OP_R);
      expect_ev(17, V_ERR);
      at(1); bus.start_i = 1'b0;
      at(20);
      chk("fetch_timeout_req_cycles", ireq_cnt - base, 16);
      chk("fetch_timeout_err", 32'(bus.err_o), 32'd1);
      done("fetch_timeout");
      do_reset("fetch_timeout_reset");

      imem_wait = 15;
      base = ireq_cnt;
      go(OP_R);
      expect_ev(16, V_FETCH);
      expect_ev(19, V_WB_R);
      at(1); bus.start_i = 1'b0;
      at(21);
      chk("ack_at_limit_req_cycles", ireq_cnt - base, 16);
      imem_wait = 0;
      exp_ret++; done("ack_at_limit");

      dmem_wait = 1000;
      go(OP_LW);
      expect_ev(1, V_FETCH);
      at(1); bus.start_i = 1'b0;
      at(6);
      chk("mid_mem_req", 32'(bus.dmem_req_o), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_reset_outs", 32'(outs), 32'd0);
      chk("async_reset_retired", 32'(bus.retired_o), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      dmem_wait = 0;
      exp_ret = '0;
      done("async_reset");

      @(posedge clk);
      #1;
      dmem_wait = 1000;
      base = dreq_cnt;
      go(OP_SW);
      expect_ev(1, V_FETCH);
      expect_ev(20, V_ERR);
      at(1); bus.start_i = 1'b0;
      at(22);
      chk("mem_timeout_req_cycles", dreq_cnt - base, 16);
      done("mem_timeout");
      do_reset("final_reset");

      chk("final_pending", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
